// File: rtl/hilo_md_ctrl_if.sv
// Execute-stage request and HI/LO write-side bundle for the multiply/divide sequencer.
interface hilo_md_ctrl_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             stall;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             hi_w;
  logic             lo_w;
  logic [WIDTH-1:0] hi_in;
  logic [WIDTH-1:0] lo_in;

  modport master (
    output start, op, rs_val, rt_val,
    input  stall, busy, done, div_by_zero, hi_w, lo_w, hi_in, lo_in
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output stall, busy, done, div_by_zero, hi_w, lo_w, hi_in, lo_in
  );
endinterface

// File: rtl/hilo_md_ctrl.sv
// HI/LO write-side sequencer: shift-add multiply, restoring divide, MTHI/MTLO,
// one registered write cycle per operation and a pipeline stall while computing.
module hilo_md_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  hilo_md_ctrl_if.slave md
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {IDLE, CALC, WRITE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             is_div_q, is_div_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             hi_w_q, hi_w_d;
  logic             lo_w_q, lo_w_d;
  logic [WIDTH-1:0] hi_in_q, hi_in_d;
  logic [WIDTH-1:0] lo_in_q, lo_in_d;

  logic             op_signed;
  logic             rt_zero;
  logic [WIDTH-1:0] abs_rs;
  logic [WIDTH-1:0] abs_rt;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;
  logic [WIDTH-1:0]   iter_hi;
  logic [WIDTH-1:0]   iter_lo;
  logic [2*WIDTH-1:0] prod_u;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign op_signed = ~md.op[0];
  assign rt_zero   = (md.rt_val == '0);
  // The most negative value maps onto itself, which reads correctly as unsigned.
  assign abs_rs    = (op_signed && md.rs_val[WIDTH-1]) ? -md.rs_val : md.rs_val;
  assign abs_rt    = (op_signed && md.rt_val[WIDTH-1]) ? -md.rt_val : md.rt_val;

  // hi_q:lo_q is the product accumulator (multiply) or remainder:quotient (divide).
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  assign div_sub   = div_shift[WIDTH-1:0] - b_q;

  always_comb begin
    if (is_div_q) begin
      iter_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
      iter_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign prod_u = {iter_hi, iter_lo};
  assign prod_s = qneg_q ? -prod_u : prod_u;
  assign res_hi = is_div_q ? (rneg_q ? -iter_hi : iter_hi) : prod_s[2*WIDTH-1:WIDTH];
  assign res_lo = is_div_q ? (qneg_q ? -iter_lo : iter_lo) : prod_s[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    hi_w_d   = 1'b0;
    lo_w_d   = 1'b0;
    hi_in_d  = hi_in_q;
    lo_in_d  = lo_in_q;
    unique case (state_q)
      IDLE: begin
        if (md.start) begin
          if (md.op == OP_MTHI) begin
            state_d = WRITE;
            done_d  = 1'b1;
            hi_w_d  = 1'b1;
            hi_in_d = md.rs_val;
          end else if (md.op == OP_MTLO) begin
            state_d = WRITE;
            done_d  = 1'b1;
            lo_w_d  = 1'b1;
            lo_in_d = md.rs_val;
          end else if (!md.op[2]) begin
            if (md.op[1] && rt_zero) begin
              state_d = WRITE;
              done_d  = 1'b1;
              dbz_d   = 1'b1;
            end else begin
              state_d  = CALC;
              cnt_d    = '0;
              hi_d     = '0;
              lo_d     = abs_rs;
              b_d      = abs_rt;
              is_div_d = md.op[1];
              qneg_d   = op_signed && (md.rs_val[WIDTH-1] ^ md.rt_val[WIDTH-1]);
              rneg_d   = op_signed && md.rs_val[WIDTH-1];
            end
          end
        end
      end
      CALC: begin
        hi_d  = iter_hi;
        lo_d  = iter_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = WRITE;
          cnt_d   = '0;
          done_d  = 1'b1;
          hi_w_d  = 1'b1;
          lo_w_d  = 1'b1;
          hi_in_d = res_hi;
          lo_in_d = res_lo;
        end
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_w_q   <= 1'b0;
      lo_w_q   <= 1'b0;
      hi_in_q  <= '0;
      lo_in_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      hi_w_q   <= hi_w_d;
      lo_w_q   <= lo_w_d;
      hi_in_q  <= hi_in_d;
      lo_in_q  <= lo_in_d;
    end
  end

  assign md.stall       = ((state_q == IDLE) && md.start && !md.op[2] && !(md.op[1] && rt_zero))
                          || (state_q == CALC);
  assign md.busy        = busy_q;
  assign md.done        = done_q;
  assign md.div_by_zero = dbz_q;
  assign md.hi_w        = hi_w_q;
  assign md.lo_w        = lo_w_q;
  assign md.hi_in       = hi_in_q;
  assign md.lo_in       = lo_in_q;
endmodule

// File: doc/hilo_md_ctrl.md
Name: hilo_md_ctrl

Overview:
- Multi-cycle multiply/divide sequencer that owns the write side of the HI and LO registers.
- Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the execute stage.
- Runs a 32-iteration shift-add multiply or restoring divide, then drives hi_w/lo_w/hi_in/lo_in for exactly one cycle.
- Asserts stall so the pipeline holds until the result is committed.

Parameters:
- WIDTH, 32, operand width and HI/LO width. The iteration count equals WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request valid, sampled on the rising edge.
- op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 invalid.
- rs_val  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- rt_val  in  WIDTH  multiplier / divisor.
- stall  out  1  combinational pipeline hold.
- busy  out  1  registered; high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- div_by_zero  out  1  one-cycle pulse on DIV/DIVU with rt_val==0.
- hi_w  out  1  HI write strobe.
- lo_w  out  1  LO write strobe.
- hi_in  out  WIDTH  HI write data.
- lo_in  out  WIDTH  LO write data.

Behaviour:
- Reset, asynchronous on rst_n low: state goes to IDLE and the counter clears.
  - All outputs go to 0: busy, done, div_by_zero, hi_w, lo_w, hi_in, lo_in.
  - Reset mid-operation abandons the operation; no HI/LO write occurs.
- States: IDLE, CALC, WRITE.
- IDLE, with start=1 and a valid op at rising edge E0 (accept):
  - MTHI/MTLO: go to WRITE; latch rs_val into hi_in (MTHI) or lo_in (MTLO).
  - MUL/DIV with divisor nonzero or MUL op: latch |rs_val|, |rt_val| (signed ops) or the raw values (unsigned ops); record the result-sign flags; clear counter; go to CALC.
  - DIV/DIVU with rt_val==0: go to WRITE with strobes suppressed.
  - Invalid op or start=0: stay in IDLE, no effect.
- CALC: one iteration per cycle, counter 0..WIDTH-1. After iteration WIDTH-1 go to WRITE. Total: WIDTH cycles in CALC.
- WRITE, exactly one cycle:
  - Outputs are registered: hi_w, lo_w, done, hi_in, lo_in.
  - MUL/DIV: hi_w=lo_w=1.
  - MTHI: hi_w=1 only. MTLO: lo_w=1 only.
  - Div-by-zero: hi_w=lo_w=0, div_by_zero=1.
  - done=1 in every case. Next state is IDLE.
  - HI/LO capture on the falling edge inside the WRITE cycle; a dependent MFHI/MFLO issued after stall drops reads the new value.
- Latency: MUL/DIV writes occur in the cycle between E(WIDTH) and E(WIDTH+1). MTHI/MTLO and div-by-zero complete in the cycle after E0.
- stall = (state==IDLE && start && op is MULT/MULTU/DIV/DIVU && rt_val-zero-check passes) || state==CALC.
  - stall is low during WRITE.
  - stall is never high for MTHI/MTLO or divide-by-zero.
- start while busy is ignored; the upstream pipeline is stalled, so this occurs only in error.
- Multiply arithmetic:
  - The unsigned 2·WIDTH product is formed by shift-add.
  - MULT negates the 64-bit product when the operand signs differ.
  - HI = product[63:32], LO = product[31:0].
- Divide arithmetic:
  - Unsigned restoring division.
  - DIV: quotient is negated when signs differ; remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives LO=0x80000000, HI=0, with wrap and no flag.
- |0x80000000| is treated as unsigned 0x80000000.

Test Plan:
1. MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF, accepted at E0 → stall high from the accept cycle through CALC. hi_w=lo_w=done=1 in the cycle after E32 with HI=0xFFFFFFFE, LO=0x00000001; stall low in that cycle.
2. MULT rs=0xFFFFFFFD rt=0x00000007 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIV rs=0xFFFFFFF9 rt=0x00000002 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. DIVU rs=100 rt=7 → LO=0x0000000E, HI=0x00000002. DIV rs=0x80000000 rt=0xFFFFFFFF → LO=0x80000000, HI=0.
4. DIVU rs=5 rt=0 → next cycle done=1, div_by_zero=1, hi_w=lo_w=0, stall never high, busy high for one cycle.
5. MTLO rs=0x12345678 → next cycle lo_w=1, lo_in=0x12345678, hi_w=0, done=1, stall never high. MTHI is the mirror case. op=110 → no response.
6. MULT in progress: start with MTHI at CALC cycle 5 → ignored, result unchanged. rst_n low at CALC cycle 10 → all outputs 0 immediately, no strobe; a new op after release runs normally.
